// File: rtl/spawn_slot_scheduler.sv
// Spawn sequencer: accepts spawner pulses, enforces a tick-based cooldown and hands (slot, y) to the draw engine.
// Optional issue timeout is enabled with `define SPAWN_SCHED_TIMEOUT_EN.
module spawn_slot_scheduler #(
    parameter int          NUM_SLOTS       = 4,
    parameter logic [9:0]  Y_MAX           = 10'd400,
    parameter int          GAP_TICKS       = 3,
    parameter int          LEVEL_UP_SPAWNS = 8,
    parameter int          TIMEOUT_CYCLES  = 1024,
    localparam int         SLOT_W          = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 tick,
    input  logic                 spawn_in,
    input  logic [9:0]           y_in,
    input  logic [NUM_SLOTS-1:0] despawn,
    input  logic                 new_ready,
    output logic                 new_valid,
    output logic [SLOT_W-1:0]    new_slot,
    output logic [9:0]           new_y,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic [1:0]           frequency,
    output logic [1:0]           level,
    output logic [7:0]           dropped
);

    typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;

    localparam logic [3:0] GAP    = 4'(GAP_TICKS);
    localparam logic [7:0] LVL_UP = 8'(LEVEL_UP_SPAWNS);

    state_t                state, state_nxt;
    logic                  new_valid_nxt;
    logic [SLOT_W-1:0]     new_slot_nxt;
    logic [9:0]            new_y_nxt;
    logic [NUM_SLOTS-1:0]  slot_valid_nxt;
    logic [1:0]            level_nxt;
    logic [1:0]            frequency_nxt;
    logic [7:0]            dropped_nxt;
    logic [3:0]            cooldown, cooldown_nxt;
    logic [7:0]            issue_cnt, issue_cnt_nxt;
    logic                  free_found;
    logic [SLOT_W-1:0]     free_idx;

`ifdef SPAWN_SCHED_TIMEOUT_EN
    localparam int            TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]          to_cnt, to_cnt_nxt;
`endif

    // Lowest-index free slot, judged on occupancy before this cycle's despawn.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        new_valid_nxt  = new_valid;
        new_slot_nxt   = new_slot;
        new_y_nxt      = new_y;
        slot_valid_nxt = slot_valid & ~despawn;
        level_nxt      = level;
        dropped_nxt    = dropped;
        cooldown_nxt   = cooldown;
        issue_cnt_nxt  = issue_cnt;
`ifdef SPAWN_SCHED_TIMEOUT_EN
        to_cnt_nxt     = to_cnt;
`endif
        case (state)
            IDLE: begin
                if (enable && spawn_in && (y_in < Y_MAX)) begin
                    if (free_found) begin
                        new_valid_nxt = 1'b1;
                        new_slot_nxt  = free_idx;
                        new_y_nxt     = y_in;
                        state_nxt     = ISSUE;
`ifdef SPAWN_SCHED_TIMEOUT_EN
                        to_cnt_nxt    = '0;
`endif
                    end else if (dropped != 8'hFF) begin
                        dropped_nxt = dropped + 8'd1;
                    end
                end
            end
            ISSUE: begin
                if (new_valid && new_ready) begin
                    // Set after the despawn mask so a same-cycle set wins.
                    slot_valid_nxt[new_slot] = 1'b1;
                    new_valid_nxt            = 1'b0;
                    if (issue_cnt + 8'd1 == LVL_UP) begin
                        issue_cnt_nxt = '0;
                        if (level != 2'd2)
                            level_nxt = level + 2'd1;
                    end else begin
                        issue_cnt_nxt = issue_cnt + 8'd1;
                    end
                    cooldown_nxt = GAP;
                    state_nxt    = COOLDOWN;
                end
`ifdef SPAWN_SCHED_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    new_valid_nxt = 1'b0;
                    if (dropped != 8'hFF)
                        dropped_nxt = dropped + 8'd1;
                    state_nxt = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
`endif
            end
            COOLDOWN: begin
                if (enable && tick) begin
                    if (cooldown == 4'd1) begin
                        cooldown_nxt = 4'd0;
                        state_nxt    = IDLE;
                    end else begin
                        cooldown_nxt = cooldown - 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        frequency_nxt = level_nxt + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            new_valid  <= 1'b0;
            new_slot   <= '0;
            new_y      <= '0;
            slot_valid <= '0;
            level      <= 2'd0;
            frequency  <= 2'd1;
            dropped    <= 8'd0;
            cooldown   <= 4'd0;
            issue_cnt  <= 8'd0;
`ifdef SPAWN_SCHED_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            new_valid  <= new_valid_nxt;
            new_slot   <= new_slot_nxt;
            new_y      <= new_y_nxt;
            slot_valid <= slot_valid_nxt;
            level      <= level_nxt;
            frequency  <= frequency_nxt;
            dropped    <= dropped_nxt;
            cooldown   <= cooldown_nxt;
            issue_cnt  <= issue_cnt_nxt;
`ifdef SPAWN_SCHED_TIMEOUT_EN
            to_cnt     <= to_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_spawn_slot_scheduler.sv
// Bench for spawn_slot_scheduler: scoreboard of expected (slot, y) issues checked at each handshake,
// plus per-scenario inline checks of occupancy, drops, level and reset behaviour.
module tb_spawn_slot_scheduler;

    typedef struct packed {
        logic [1:0] slot;
        logic [9:0] y;
    } issue_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick;
    logic       spawn_in;
    logic [9:0] y_in;
    logic [3:0] despawn;
    logic       new_ready;
    logic       new_valid;
    logic [1:0] new_slot;
    logic [9:0] new_y;
    logic [3:0] slot_valid;
    logic [1:0] frequency;
    logic [1:0] level;
    logic [7:0] dropped;

    int     n_cmp = 0;
    int     n_bad = 0;
    issue_t exp_q[$];

    spawn_slot_scheduler dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .spawn_in(spawn_in), .y_in(y_in), .despawn(despawn), .new_ready(new_ready),
        .new_valid(new_valid), .new_slot(new_slot), .new_y(new_y),
        .slot_valid(slot_valid), .frequency(frequency), .level(level), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // Handshake monitor: an accepted issue must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && new_valid && new_ready) begin
            issue_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got slot=%0d y=%0d, required none", new_slot, new_y);
            end else begin
                e = exp_q.pop_front();
                if (new_slot !== e.slot || new_y !== e.y) begin
                    n_bad++;
                    $display("FAIL sb_issue: got slot=%0d y=%0d, required slot=%0d y=%0d",
                             new_slot, new_y, e.slot, e.y);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
        end
    endtask

    // Issue one spawn with ready high, then run the cooldown out.
    task automatic issue_one(input logic [9:0] y, input logic [1:0] slot);
        issue_t e;
        e.slot = slot;
        e.y    = y;
        exp_q.push_back(e);
        spawn_in  = 1'b1;
        y_in      = y;
        new_ready = 1'b1;
        step(1);
        spawn_in = 1'b0;
        n_cmp++;
        if (new_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL issue_vld: new_valid=%b, required 1 (y=%0d)", new_valid, y);
        end
        step(1);
        pulse_ticks(3);
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; tick = 1'b0; spawn_in = 1'b0;
        y_in = '0; despawn = '0; new_ready = 1'b0;
        step(2);
        reset = 1'b0;
        n_cmp++;
        if ({new_valid, new_slot, new_y, slot_valid, frequency, level, dropped} !==
            {1'b0, 2'd0, 10'd0, 4'b0000, 2'b01, 2'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_state: vld=%b slot=%0d y=%0d sv=%b freq=%b lvl=%0d drop=%0d, required 0 0 0 0000 01 0 0",
                     new_valid, new_slot, new_y, slot_valid, frequency, level, dropped);
        end
    endtask

    task automatic test_first_issue;
        issue_t e;
        e.slot = 2'd0; e.y = 10'd100;
        exp_q.push_back(e);
        spawn_in = 1'b1; y_in = 10'd100; new_ready = 1'b1;
        step(1);
        spawn_in = 1'b0;
        n_cmp++;
        if (new_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL first_latency: new_valid=%b, required 1", new_valid);
        end
        step(1);
        n_cmp++;
        if (new_valid !== 1'b0 || slot_valid !== 4'b0001) begin
            n_bad++;
            $display("FAIL first_done: vld=%b sv=%b, required 0 0001", new_valid, slot_valid);
        end
    endtask

    task automatic test_cooldown;
        issue_t e;
        e.slot = 2'd1; e.y = 10'd200;
        exp_q.push_back(e);
        spawn_in = 1'b1; y_in = 10'd200;
        for (int t = 1; t <= 3; t++) begin
            pulse_ticks(1);
            step(1);
            n_cmp++;
            if (new_valid !== (t == 3)) begin
                n_bad++;
                $display("FAIL cooldown_hold: after tick %0d vld=%b, required %b", t, new_valid, t == 3);
            end
        end
        spawn_in = 1'b0;
        step(1);
        n_cmp++;
        if (slot_valid !== 4'b0011) begin
            n_bad++;
            $display("FAIL cooldown_issue: sv=%b, required 0011", slot_valid);
        end
        pulse_ticks(3);
    endtask

    task automatic test_full_drop;
        issue_one(10'd300, 2'd2);
        issue_one(10'd301, 2'd3);
        n_cmp++;
        if (slot_valid !== 4'b1111) begin
            n_bad++;
            $display("FAIL full_mask: sv=%b, required 1111", slot_valid);
        end
        spawn_in = 1'b1; y_in = 10'd50;
        step(1);
        spawn_in = 1'b0;
        n_cmp++;
        if (dropped !== 8'd1 || new_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL full_drop: drop=%0d vld=%b, required 1 0", dropped, new_valid);
        end
        despawn = 4'b0100;
        step(1);
        despawn = 4'b0000;
        n_cmp++;
        if (slot_valid !== 4'b1011) begin
            n_bad++;
            $display("FAIL despawn_mask: sv=%b, required 1011", slot_valid);
        end
        issue_one(10'd60, 2'd2);
        n_cmp++;
        if (slot_valid !== 4'b1111 || dropped !== 8'd1) begin
            n_bad++;
            $display("FAIL refill: sv=%b drop=%0d, required 1111 1", slot_valid, dropped);
        end
    endtask

    task automatic test_range_and_stall;
        issue_t e;
        despawn = 4'b1111;
        step(1);
        despawn = 4'b0000;
        spawn_in = 1'b1; y_in = 10'd450;
        step(2);
        y_in = 10'd400;
        step(2);
        spawn_in = 1'b0;
        n_cmp++;
        if (new_valid !== 1'b0 || dropped !== 8'd1 || slot_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL out_of_range: vld=%b drop=%0d sv=%b, required 0 1 0000", new_valid, dropped, slot_valid);
        end
        e.slot = 2'd0; e.y = 10'd399;
        exp_q.push_back(e);
        new_ready = 1'b0; spawn_in = 1'b1; y_in = 10'd399;
        step(1);
        spawn_in = 1'b0; y_in = 10'd7;
        for (int c = 0; c < 20; c++) begin
            n_cmp++;
            if (new_valid !== 1'b1 || new_slot !== 2'd0 || new_y !== 10'd399) begin
                n_bad++;
                $display("FAIL stall_stable: cycle %0d vld=%b slot=%0d y=%0d, required 1 0 399",
                         c, new_valid, new_slot, new_y);
            end
            step(1);
        end
        new_ready = 1'b1; despawn = 4'b0001;
        step(1);
        despawn = 4'b0000;
        n_cmp++;
        if (slot_valid !== 4'b0001 || new_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL set_wins: sv=%b vld=%b, required 0001 0", slot_valid, new_valid);
        end
        pulse_ticks(3);
    endtask

    task automatic test_level;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            logic [1:0] lv;
            issue_one(10'(n), 2'd0);
            despawn = 4'b0001;
            step(1);
            despawn = 4'b0000;
            lv = (n >= 16) ? 2'd2 : (n >= 8) ? 2'd1 : 2'd0;
            if (n == 7 || n == 8 || n == 16 || n == 24) begin
                n_cmp++;
                if (level !== lv || frequency !== lv + 2'd1) begin
                    n_bad++;
                    $display("FAIL level_after_%0d: lvl=%0d freq=%b, required %0d %b",
                             n, level, frequency, lv, lv + 2'd1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_issue;
        issue_one(10'd77, 2'd0);
        new_ready = 1'b0; spawn_in = 1'b1; y_in = 10'd123;
        step(1);
        spawn_in = 1'b0;
        n_cmp++;
        if (new_valid !== 1'b1 || new_slot !== 2'd1) begin
            n_bad++;
            $display("FAIL mid_pending: vld=%b slot=%0d, required 1 1", new_valid, new_slot);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_cmp++;
        if (new_valid !== 1'b0 || slot_valid !== 4'b0000 || level !== 2'd0 ||
            frequency !== 2'b01 || dropped !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_reset: vld=%b sv=%b lvl=%0d freq=%b drop=%0d, required 0 0000 0 01 0",
                     new_valid, slot_valid, level, frequency, dropped);
        end
`ifdef SPAWN_SCHED_TIMEOUT_EN
        spawn_in = 1'b1; y_in = 10'd5;
        step(1);
        spawn_in = 1'b0;
        step(1023);
        n_cmp++;
        if (new_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_early: vld=%b, required 1", new_valid);
        end
        step(1);
        n_cmp++;
        if (new_valid !== 1'b0 || dropped !== 8'd1 || slot_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL timeout_abort: vld=%b drop=%0d sv=%b, required 0 1 0000", new_valid, dropped, slot_valid);
        end
`endif
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d issues outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_first_issue;
        test_cooldown;
        test_full_drop;
        test_range_and_stall;
        test_level;
        test_reset_mid_issue;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
